// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU command sequencer: opcodes, FSM states
// and the opcode validity check.
package uart_alu_pkg;

  localparam int NB_OP_DEF = 6;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  // True when the opcode field names one of the supported ALU operations.
  function automatic logic op_is_valid(input logic [NB_OP_DEF-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Byte-level handshake between the sequencer, the UART and the ALU.
// master = sequencer side, slave = UART/ALU side.
interface uart_alu_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_timeout;
  logic               o_op_err;
  logic               o_overrun;

  modport master (
    input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
    output o_data_a, o_data_b, o_op, o_tx_start, o_tx_data,
           o_busy, o_timeout, o_op_err, o_overrun
  );

  modport slave (
    output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
    input  o_data_a, o_data_b, o_op, o_tx_start, o_tx_data,
           o_busy, o_timeout, o_op_err, o_overrun
  );
endinterface

// File: rtl/inter_byte_timer.sv
// Counts idle cycles between bytes of one command. expire flags the cycle
// whose clock edge would bring the count to TIMEOUT_CYC-1, so the owner can
// register its timeout pulse on that same edge.
module inter_byte_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  // Idle-cycle counter; clear has priority over counting.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end

  assign expire = enable && (cnt == CW'(TIMEOUT_CYC - 2));
endmodule

// File: rtl/uart_alu_ctrl.sv
// Command sequencer: gathers A, B and opcode bytes from the UART, runs them
// through the ALU and sends the result back as one tx transfer.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = NB_OP_DEF,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_alu_ctrl_if.master bus
);
  state_t             state;
  logic [NB_DATA-1:0] data_a, data_b, tx_data;
  logic [NB_OP-1:0]   op;
  logic               tx_start, busy, timeout, op_err, overrun;
  logic               in_wait, expire, op_ok;

  assign in_wait = (state == WAIT_B) || (state == WAIT_OP);
  // Upper byte bits must be zero; a stray high bit makes the opcode invalid.
  assign op_ok   = (bus.i_rx_data[NB_DATA-1:NB_OP] == '0) &&
                   op_is_valid(bus.i_rx_data[NB_OP-1:0]);

  inter_byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (bus.i_rx_done),
    .enable  (in_wait && !bus.i_rx_done),
    .expire  (expire)
  );

  // Command FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      data_a   <= '0;
      data_b   <= '0;
      op       <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      op_err   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      timeout  <= 1'b0;
      op_err   <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        IDLE: if (bus.i_rx_done) begin
          data_a <= bus.i_rx_data;
          state  <= WAIT_B;
          busy   <= 1'b1;
        end
        WAIT_B: begin
          if (bus.i_rx_done) begin
            data_b <= bus.i_rx_data;
            state  <= WAIT_OP;
          end else if (expire) begin
            timeout <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end
        WAIT_OP: begin
          if (bus.i_rx_done) begin
            if (op_ok) begin
              op    <= bus.i_rx_data[NB_OP-1:0];
              state <= CALC;
            end else begin
              op_err <= 1'b1;
              state  <= IDLE;
              busy   <= 1'b0;
            end
          end else if (expire) begin
            timeout <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end
        CALC: begin
          tx_data  <= bus.i_alu_result;
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: if (bus.i_tx_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Bytes arriving while a result is in flight are dropped and flagged.
      if (bus.i_rx_done && (state == CALC || state == SEND || state == WAIT_TX))
        overrun <= 1'b1;
    end
  end

  assign bus.o_data_a   = data_a;
  assign bus.o_data_b   = data_b;
  assign bus.o_op       = op;
  assign bus.o_tx_start = tx_start;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_busy     = busy;
  assign bus.o_timeout  = timeout;
  assign bus.o_op_err   = op_err;
  assign bus.o_overrun  = overrun;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: randomized and directed commands checked against
// a command-level model (accepted operands, opcode table, ALU arithmetic).
module tb_uart_alu_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   tx_pulses = 0;

  logic [7:0] exp_a, exp_b, exp_tx;
  logic [5:0] exp_op;
  logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  uart_alu_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(100)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  function automatic logic [7:0] alu_model(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_valid(logic [7:0] b);
    foreach (valid_ops[i]) if (valid_ops[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  assign bus.i_alu_result = alu_model(bus.o_data_a, bus.o_data_b, bus.o_op);

  always @(negedge clk) if (bus.o_tx_start) tx_pulses++;

  // Called on a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_done = 1'b1; bus.i_rx_data = b;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic run_cmd(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] opb, input bit stray_tx);
    send_byte(a);
    exp_a = a;
    checks++; if (bus.o_busy !== 1'b1 || bus.o_data_a !== exp_a) begin errors++;
      $display("FAIL %s byte_a: busy=%0b a=%h want busy=1 a=%h", nm, bus.o_busy, bus.o_data_a, exp_a); end
    if (stray_tx) begin
      bus.i_tx_done = 1'b1; @(negedge clk); bus.i_tx_done = 1'b0;
      checks++; if (bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin errors++;
        $display("FAIL %s stray_tx: busy=%0b tx_start=%0b want 1,0", nm, bus.o_busy, bus.o_tx_start); end
    end
    send_byte(b);
    exp_b = b;
    checks++; if (bus.o_data_b !== exp_b) begin errors++;
      $display("FAIL %s byte_b: got %h want %h", nm, bus.o_data_b, exp_b); end
    send_byte(opb);
    if (is_valid(opb)) begin
      exp_op = opb[5:0];
      exp_tx = alu_model(exp_a, exp_b, exp_op);
      checks++; if (bus.o_op !== exp_op || bus.o_tx_start !== 1'b0 || bus.o_op_err !== 1'b0) begin errors++;
        $display("FAIL %s calc: op=%h tx_start=%0b op_err=%0b want op=%h,0,0", nm, bus.o_op, bus.o_tx_start, bus.o_op_err, exp_op); end
      @(negedge clk);
      checks++; if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== exp_tx) begin errors++;
        $display("FAIL %s send: tx_start=%0b tx_data=%h want 1 %h", nm, bus.o_tx_start, bus.o_tx_data, exp_tx); end
      @(negedge clk);
      checks++; if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) begin errors++;
        $display("FAIL %s wait_tx: tx_start=%0b busy=%0b want 0 1", nm, bus.o_tx_start, bus.o_busy); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.i_tx_done = 1'b1; @(negedge clk); bus.i_tx_done = 1'b0;
      checks++; if (bus.o_busy !== 1'b0 || bus.o_tx_data !== exp_tx) begin errors++;
        $display("FAIL %s done: busy=%0b tx_data=%h want 0 %h", nm, bus.o_busy, bus.o_tx_data, exp_tx); end
    end else begin
      checks++; if (bus.o_op_err !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_op !== exp_op) begin errors++;
        $display("FAIL %s op_err: op_err=%0b busy=%0b op=%h want 1 0 %h", nm, bus.o_op_err, bus.o_busy, bus.o_op, exp_op); end
      @(negedge clk);
      checks++; if (bus.o_op_err !== 1'b0 || bus.o_tx_start !== 1'b0) begin errors++;
        $display("FAIL %s op_err_once: op_err=%0b tx_start=%0b want 0 0", nm, bus.o_op_err, bus.o_tx_start); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_tx_start, bus.o_tx_data, bus.o_busy,
                   bus.o_timeout, bus.o_op_err, bus.o_overrun} !== '0) begin errors++;
      $display("FAIL reset_state: outputs not all zero a=%h b=%h op=%h busy=%0b", bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_busy); end
    rst_n = 1'b1;
    exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_cmd("add", 8'h05, 8'h03, 8'h20, 1'b0);
    checks++; if (exp_tx !== 8'h08 || bus.o_tx_data !== 8'h08) begin errors++;
      $display("FAIL add_result: got %h want 08", bus.o_tx_data); end
  endtask

  task automatic test_invalid_op();
    int p0;
    p0 = tx_pulses;
    run_cmd("inv_op", 8'h10, 8'h01, 8'h3F, 1'b0);
    checks++; if (tx_pulses != p0) begin errors++;
      $display("FAIL inv_op_no_tx: got %0d tx pulses want 0", tx_pulses - p0); end
    run_cmd("sub", 8'h09, 8'h04, 8'h22, 1'b0);
    checks++; if (bus.o_tx_data !== 8'h05) begin errors++;
      $display("FAIL sub_result: got %h want 05", bus.o_tx_data); end
  endtask

  task automatic test_timeout();
    int pulses;
    // Silence after A: pulse expected exactly on the 99th edge.
    send_byte(8'hAA);
    pulses = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.o_timeout) pulses++;
      checks++; if (bus.o_timeout !== (k == 99)) begin errors++;
        $display("FAIL timeout_edge%0d: got %0b want %0b", k, bus.o_timeout, (k == 99)); end
    end
    checks++; if (pulses != 1 || bus.o_busy !== 1'b0 || bus.o_data_a !== 8'hAA) begin errors++;
      $display("FAIL timeout_abort: pulses=%0d busy=%0b a=%h want 1 0 aa", pulses, bus.o_busy, bus.o_data_a); end
    exp_a = 8'hAA;
    run_cmd("after_to", 8'h0F, 8'h33, 8'h24, 1'b0);
    // Byte landing on the expiry edge is accepted instead.
    send_byte(8'hAA);
    pulses = 0;
    repeat (98) begin @(negedge clk); if (bus.o_timeout) pulses++; end
    send_byte(8'h11);
    if (bus.o_timeout) pulses++;
    checks++; if (pulses != 0 || bus.o_data_b !== 8'h11 || bus.o_busy !== 1'b1) begin errors++;
      $display("FAIL expiry_win: pulses=%0d b=%h busy=%0b want 0 11 1", pulses, bus.o_data_b, bus.o_busy); end
    exp_a = 8'hAA; exp_b = 8'h11;
    send_byte(8'h26);
    exp_op = 6'h26; exp_tx = alu_model(exp_a, exp_b, exp_op);
    @(negedge clk);
    checks++; if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== exp_tx || bus.o_timeout !== 1'b0) begin errors++;
      $display("FAIL expiry_cmd: tx_start=%0b tx_data=%h want 1 %h", bus.o_tx_start, bus.o_tx_data, exp_tx); end
    @(negedge clk);
    bus.i_tx_done = 1'b1; @(negedge clk); bus.i_tx_done = 1'b0;
  endtask

  task automatic test_overrun();
    send_byte(8'h5A); send_byte(8'h0C); send_byte(8'h25);
    exp_a = 8'h5A; exp_b = 8'h0C; exp_op = 6'h25; exp_tx = alu_model(exp_a, exp_b, exp_op);
    @(negedge clk); @(negedge clk);
    send_byte(8'h77);
    checks++; if (bus.o_overrun !== 1'b1 || bus.o_data_a !== exp_a || bus.o_busy !== 1'b1) begin errors++;
      $display("FAIL overrun: ovr=%0b a=%h busy=%0b want 1 %h 1", bus.o_overrun, bus.o_data_a, bus.o_busy, exp_a); end
    @(negedge clk);
    checks++; if (bus.o_overrun !== 1'b0) begin errors++;
      $display("FAIL overrun_once: got %0b want 0", bus.o_overrun); end
    bus.i_tx_done = 1'b1; @(negedge clk); bus.i_tx_done = 1'b0;
    checks++; if (bus.o_busy !== 1'b0 || bus.o_tx_data !== exp_tx || bus.o_data_a !== exp_a) begin errors++;
      $display("FAIL overrun_tx: busy=%0b tx=%h a=%h want 0 %h %h", bus.o_busy, bus.o_tx_data, bus.o_data_a, exp_tx, exp_a); end
  endtask

  task automatic test_reset_mid();
    int p0;
    for (int w = 0; w < 2; w++) begin
      p0 = tx_pulses;
      send_byte(8'h21); send_byte(8'h42);
      if (w == 1) begin send_byte(8'h20); repeat (3) @(negedge clk); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_tx_start, bus.o_tx_data, bus.o_busy,
                     bus.o_timeout, bus.o_op_err, bus.o_overrun} !== '0) begin errors++;
        $display("FAIL reset_mid%0d: a=%h b=%h op=%h tx=%h busy=%0b want all 0", w, bus.o_data_a, bus.o_data_b, bus.o_op, bus.o_tx_data, bus.o_busy); end
      @(negedge clk); rst_n = 1'b1;
      exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0;
      checks++; if (tx_pulses != p0 + w) begin errors++;
        $display("FAIL reset_mid%0d_tx: got %0d pulses want %0d", w, tx_pulses - p0, w); end
      run_cmd("post_reset", 8'hC3, 8'h3C, 8'h26, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = tx_pulses;
    run_cmd("b2b_1", 8'hF0, 8'h02, 8'h03, 1'b0);
    run_cmd("b2b_2", 8'hF0, 8'h02, 8'h03, 1'b1);
    checks++; if (tx_pulses != p0 + 2 || bus.o_tx_data !== 8'hFC) begin errors++;
      $display("FAIL b2b: pulses=%0d tx=%h want 2 fc", tx_pulses - p0, bus.o_tx_data); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, o;
    for (int n = 0; n < 16; n++) begin
      a = 8'($urandom); b = 8'($urandom);
      o = ($urandom_range(0, 3) != 0) ? valid_ops[$urandom_range(0, 7)] : 8'($urandom);
      run_cmd("rand", a, b, o, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_rx_done = 1'b0; bus.i_rx_data = '0; bus.i_tx_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_invalid_op();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
